// File: rtl/sc_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory (or a bench model) is the slave.
interface sc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/sc_fetch.sv
// Fetch/PC sequencing stage for the single-cycle MIPS core: holds the PC,
// fetches over the imem handshake and commits the next PC chosen by pcsource.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | one cycle after reset, no request issued
// FETCH  | imem_req high at pc, waiting for imem_ack to capture inst
// EXEC   | inst valid and stable, waiting for commit to advance pc
module sc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       ra,
  input  logic              commit,
  sc_fetch_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [31:0]       retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retired_q;
  logic        inst_load;
  logic        commit_en;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] jr_target;
  logic [31:0] npc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    imem.req   = 1'b0;
    inst_valid = 1'b0;
    inst_load  = 1'b0;
    commit_en  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          inst_load = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        if (commit) begin
          commit_en = 1'b1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Branch/jump targets are pure functions of the held pc and inst.
  always_comb begin
    pc4       = pc_q + 32'd4;
    bpc       = pc4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    jpc       = {pc4[31:28], inst_q[25:0], 2'b00};
    jr_target = ra & 32'hFFFF_FFFC;
    case (pcsource)
      2'b00:   npc = pc4;
      2'b01:   npc = bpc;
      2'b10:   npc = jr_target;
      default: npc = jpc;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      if (inst_load) inst_q <= imem.rdata;
      if (commit_en) begin
        pc_q      <= npc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign imem.addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_sc_fetch.sv
// Directed bench for sc_fetch: sequential fetch, branch/jump/jr targets,
// wait states, async reset mid-EXEC and pc/retired wrap.
`timescale 1ns/1ps
module tb_sc_fetch;

   logic        clock;
   logic        resetn;
   logic [1:0]  pcsource;
   logic [31:0] ra;
   logic        commit;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] retired;

   int n_checks = 0;
   int n_errors = 0;

   sc_fetch_if imem_bus ();

   sc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .pcsource   (pcsource),
      .ra         (ra),
      .commit     (commit),
      .imem       (imem_bus.master),
      .pc         (pc),
      .pc4        (pc4),
      .inst       (inst),
      .inst_valid (inst_valid),
      .retired    (retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn         = 1'b0;
      pcsource       = 2'b00;
      ra             = 32'd0;
      commit         = 1'b0;
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = 32'd0;
      #2;
      chk("rst_req",     imem_bus.req, 1'b0);
      chk("rst_valid",   inst_valid,   1'b0);
      chk("rst_pc",      pc,           32'h0);
      chk("rst_pc4",     pc4,          32'h4);
      chk("rst_inst",    inst,         32'h0);
      chk("rst_retired", retired,      32'h0);

      @(negedge clock);
      resetn = 1'b1;
      tick();
      chk("idle_to_fetch_req", imem_bus.req, 1'b1);

      // Sequential run: zero-wait memory, commit held high.
      imem_bus.ack = 1'b1;
      commit       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         imem_bus.rdata = 32'h2000_0000 + i;
         chk("seq_req",  imem_bus.req,  1'b1);
         chk("seq_addr", imem_bus.addr, 32'(4 * i));
         tick();
         chk("seq_valid",  inst_valid,   1'b1);
         chk("seq_inst",   inst,         32'h2000_0000 + i);
         chk("seq_reqlow", imem_bus.req, 1'b0);
         tick();
      end
      chk("seq_retired", retired, 32'd4);
      commit       = 1'b0;
      imem_bus.ack = 1'b0;

      // Jump 0x10 -> 0x40
      imem_bus.rdata = 32'h0800_0010;
      imem_bus.ack   = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      pcsource     = 2'b11;
      commit       = 1'b1;
      tick();
      commit = 1'b0;
      chk("jmp_to_40", imem_bus.addr, 32'h0000_0040);

      // Branch back by -2 words from 0x40
      imem_bus.rdata = 32'h1000_FFFE;
      imem_bus.ack   = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      chk("br_inst", inst, 32'h1000_FFFE);
      pcsource = 2'b01;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("br_back", imem_bus.addr, 32'h0000_003C);

      // jr with unaligned ra -> 0x1000_0010
      imem_bus.rdata = 32'h0;
      imem_bus.ack   = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      pcsource = 2'b10;
      ra       = 32'h1000_0013;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("jr_mask", imem_bus.addr, 32'h1000_0010);

      // Jump keeps pc4[31:28]
      imem_bus.rdata = 32'h0800_0100;
      imem_bus.ack   = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      pcsource = 2'b11;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("jmp_region", pc, 32'h1000_0400);

      imem_bus.rdata = 32'h0;
      imem_bus.ack   = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      pcsource = 2'b10;
      ra       = 32'h0000_0123;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("jr_120", pc, 32'h0000_0120);
      chk("retired_9", retired, 32'd9);

      // Wait states, with commit high (ignored in FETCH)
      commit         = 1'b1;
      imem_bus.rdata = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         chk("ws_req",     imem_bus.req,  1'b1);
         chk("ws_addr",    imem_bus.addr, 32'h0000_0120);
         chk("ws_inst",    inst,          32'h0);
         chk("ws_retired", retired,       32'd9);
         tick();
      end
      imem_bus.rdata = 32'h0123_4567;
      imem_bus.ack   = 1'b1;
      chk("ws_req4",  imem_bus.req,  1'b1);
      chk("ws_addr4", imem_bus.addr, 32'h0000_0120);
      tick();
      commit = 1'b0;
      chk("ws_inst_cap", inst,       32'h0123_4567);
      chk("ws_valid",    inst_valid, 1'b1);

      // ack during EXEC has no effect
      imem_bus.rdata = 32'hFFFF_FFFF;
      tick();
      imem_bus.ack = 1'b0;
      chk("exec_ack_inst",    inst,       32'h0123_4567);
      chk("exec_ack_valid",   inst_valid, 1'b1);
      chk("exec_ack_pc",      pc,         32'h0000_0120);
      chk("exec_ack_retired", retired,    32'd9);
      pcsource = 2'b00;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("seq_after_ws", imem_bus.addr, 32'h0000_0124);
      chk("retired_10",   retired,       32'd10);

      // Async reset between edges during EXEC
      imem_bus.ack = 1'b1;
      tick();
      chk("pre_rst_valid", inst_valid, 1'b1);
      #3;
      resetn = 1'b0;
      #1;
      chk("arst_pc",      pc,           32'h0);
      chk("arst_retired", retired,      32'h0);
      chk("arst_valid",   inst_valid,   1'b0);
      chk("arst_req",     imem_bus.req, 1'b0);
      chk("arst_inst",    inst,         32'h0);
      @(negedge clock);
      resetn = 1'b1;
      tick();
      chk("arst_first_req",  imem_bus.req,  1'b1);
      chk("arst_first_addr", imem_bus.addr, 32'h0);

      // pc wrap through 0xFFFF_FFFC
      tick();
      imem_bus.ack = 1'b0;
      pcsource = 2'b10;
      ra       = 32'hFFFF_FFFF;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("wrap_top_addr", imem_bus.addr, 32'hFFFF_FFFC);
      chk("wrap_pc4",      pc4,           32'h0);
      imem_bus.ack = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      pcsource = 2'b00;
      commit   = 1'b1;
      tick();
      commit = 1'b0;
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_retired_pre", retired, 32'd2);

      // retired wrap, preloaded while in FETCH
      force dut.retired_q = 32'hFFFF_FFFF;
      tick();
      release dut.retired_q;
      #1;
      chk("ret_preload", retired, 32'hFFFF_FFFF);
      imem_bus.ack = 1'b1;
      tick();
      imem_bus.ack = 1'b0;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("ret_wrap", retired, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
